// File: rtl/pdm_to_pcm.sv
// PDM microphone front end: generates the mic clock, samples the 1-bit stream and
// decimates it with a 3rd-order CIC into saturated signed PCM with a 1-cycle valid.
module pdm_to_pcm #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int CLK_DIV      = 32,
    parameter int DECIMATION   = 64,
    parameter int WARMUP       = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable_i,
    output logic                           pdm_clk_o,
    input  logic                           pdm_data_i,
    output logic signed [SAMPLE_WIDTH-1:0] pcm_o,
    output logic                           pcm_valid_o
);
    localparam int LOG2_DEC = $clog2(DECIMATION);
    localparam int CIC_W    = 3 * LOG2_DEC + 2;
    localparam int SHIFT    = 3 * LOG2_DEC + 1 - SAMPLE_WIDTH;
    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int WARM_W   = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0]    STROBE_AT = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [LOG2_DEC-1:0] DEC_LAST  = LOG2_DEC'(DECIMATION - 1);
    localparam logic [WARM_W-1:0]   WARM_DONE = WARM_W'(WARMUP);

    localparam logic signed [CIC_W-1:0] PCM_MAX = CIC_W'((2 ** (SAMPLE_WIDTH - 1)) - 1);
    localparam logic signed [CIC_W-1:0] PCM_MIN = -PCM_MAX - 1;

    logic [DIV_W-1:0]               div_cnt_reg;
    logic                           pdm_clk_reg;
    logic [1:0]                     sync_reg;
    logic [LOG2_DEC-1:0]            dec_cnt_reg;
    logic                           dec_flag_reg;
    logic [WARM_W-1:0]              warm_cnt_reg;
    logic signed [SAMPLE_WIDTH-1:0] pcm_reg;
    logic                           pcm_valid_reg;

    logic signed [CIC_W-1:0] int_reg [3];
    logic signed [CIC_W-1:0] dly_reg [3];
    logic signed [CIC_W-1:0] int_in  [3];
    logic signed [CIC_W-1:0] comb    [4];
    logic signed [CIC_W-1:0] scaled;
    logic signed [SAMPLE_WIDTH-1:0] pcm_sat;
    logic                    strobe;

    assign strobe = (div_cnt_reg == STROBE_AT);

    // Bit 1 maps to +1, bit 0 to -1 (all ones in two's complement)
    assign int_in[0] = sync_reg[1] ? CIC_W'(1) : '1;
    assign comb[0]   = int_reg[2];

    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_int_chain
            assign int_in[gi] = int_reg[gi-1];
        end
        for (genvar gi = 0; gi < 3; gi++) begin : g_comb_chain
            assign comb[gi+1] = comb[gi] - dly_reg[gi];
        end
    endgenerate

    assign scaled = comb[3] >>> SHIFT;

    always_comb begin
        pcm_sat = scaled[SAMPLE_WIDTH-1:0];
        if (scaled > PCM_MAX) begin
            pcm_sat = PCM_MAX[SAMPLE_WIDTH-1:0];
        end else if (scaled < PCM_MIN) begin
            pcm_sat = PCM_MIN[SAMPLE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], pdm_data_i};
        end
    end

    // Comb delays and the output register share the dec_flag edge so the
    // sample appears two cycles after the strobe that closed the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg   <= '0;
            pdm_clk_reg   <= 1'b0;
            dec_cnt_reg   <= '0;
            dec_flag_reg  <= 1'b0;
            warm_cnt_reg  <= '0;
            pcm_reg       <= '0;
            pcm_valid_reg <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                int_reg[k] <= '0;
                dly_reg[k] <= '0;
            end
        end else if (!enable_i) begin
            div_cnt_reg   <= '0;
            pdm_clk_reg   <= 1'b0;
            dec_cnt_reg   <= '0;
            dec_flag_reg  <= 1'b0;
            warm_cnt_reg  <= '0;
            pcm_valid_reg <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                int_reg[k] <= '0;
                dly_reg[k] <= '0;
            end
        end else begin
            div_cnt_reg   <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
            pdm_clk_reg   <= (div_cnt_reg < DIV_HALF);
            dec_flag_reg  <= 1'b0;
            pcm_valid_reg <= 1'b0;
            if (strobe) begin
                for (int k = 0; k < 3; k++) begin
                    int_reg[k] <= int_reg[k] + int_in[k];
                end
                dec_cnt_reg  <= dec_cnt_reg + 1'b1;
                dec_flag_reg <= (dec_cnt_reg == DEC_LAST);
            end
            if (dec_flag_reg) begin
                for (int k = 0; k < 3; k++) begin
                    dly_reg[k] <= comb[k];
                end
                if (warm_cnt_reg < WARM_DONE) begin
                    warm_cnt_reg <= warm_cnt_reg + 1'b1;
                end else begin
                    pcm_reg       <= pcm_sat;
                    pcm_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign pdm_clk_o   = pdm_clk_reg;
    assign pcm_o       = pcm_reg;
    assign pcm_valid_o = pcm_valid_reg;

endmodule

// File: tb/tb_pdm_to_pcm.sv
// Directed bench for pdm_to_pcm: PDM patterns are driven from the mic clock, expected
// PCM values are queued per enable and popped whenever pcm_valid_o pulses.
module tb_pdm_to_pcm;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable_i = 1'b0;
    logic               pdm_clk_o;
    logic               pdm_data_i;
    logic signed [15:0] pcm_o;
    logic               pcm_valid_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int exp_q[$];
    int vcyc[$];

    logic [3:0] pat = 4'hF;
    int         plen = 1;
    int         falls = 0;
    int         base = 0;

    pdm_to_pcm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable_i),
        .pdm_clk_o   (pdm_clk_o),
        .pdm_data_i  (pdm_data_i),
        .pcm_o       (pcm_o),
        .pcm_valid_o (pcm_valid_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge pdm_clk_o) falls <= falls + 1;

    // Mic model: a new bit after every falling edge of the mic clock
    assign pdm_data_i = pat[(falls - base) % plen];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock step; any valid pulse seen here is scored against the queue
    task automatic tick();
        int e;
        @(negedge clk);
        if (pcm_valid_o === 1'b1) begin
            vcyc.push_back(cyc);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 99999;
            $display("valid cycle=%0d pcm=%0d expected=%0d", cyc, pcm_o, e);
            checks++;
            assert (int'(pcm_o) === e) else begin
                failures++;
                $error("FAIL sb_pcm observed=%0d expected=%0d", pcm_o, e);
            end
        end
    endtask

    task automatic wait_valids(input int count, input int budget, input string tag);
        int target;
        int spent;
        target = vcyc.size() + count;
        spent = 0;
        while (vcyc.size() < target && spent < budget) begin
            tick();
            spent++;
        end
        chk({tag, "_arrived"}, 32'(vcyc.size() >= target), 1);
    endtask

    task automatic start_pattern(input logic [3:0] p, input int len, output int t0);
        pat = p;
        plen = len;
        base = falls;
        enable_i = 1'b1;
        t0 = cyc;
    endtask

    task automatic stop_run();
        enable_i = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        int t0;
        int idx;
        logic [63:0] clk_seen;
        logic [63:0] clk_exp;

        repeat (3) tick();
        chk("rst_pdm_clk", pdm_clk_o, 0);
        chk("rst_pcm", pcm_o, 0);
        chk("rst_valid", pcm_valid_o, 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Clock waveform plus all-ones full scale
        start_pattern(4'hF, 1, t0);
        for (int k = 0; k < 3; k++) exp_q.push_back(32767);
        idx = vcyc.size();
        for (int k = 0; k < 64; k++) begin
            clk_seen[k] = pdm_clk_o;
            clk_exp[k]  = (k == 0) ? 1'b0 : (((k - 1) % 32) < 16);
            tick();
        end
        checks++;
        assert (clk_seen === clk_exp) else begin
            failures++;
            $error("FAIL pdm_clk_wave observed=%h expected=%h", clk_seen, clk_exp);
        end
        wait_valids(3, 8177 + 4096 + 200, "ones");
        if (vcyc.size() >= idx + 3) begin
            chk("ones_first_lat", vcyc[idx] - t0, 8177);
            chk("ones_interval1", vcyc[idx+1] - vcyc[idx], 2048);
            chk("ones_interval2", vcyc[idx+2] - vcyc[idx+1], 2048);
        end
        enable_i = 1'b0;
        tick();
        chk("dis_pdm_clk", pdm_clk_o, 0);
        repeat (4) tick();

        // All zeros
        start_pattern(4'h0, 1, t0);
        exp_q.push_back(-32768);
        exp_q.push_back(-32768);
        idx = vcyc.size();
        wait_valids(2, 8177 + 2048 + 200, "zeros");
        if (vcyc.size() > idx) chk("zeros_first_lat", vcyc[idx] - t0, 8177);
        stop_run();

        // Alternating and 75% ones
        start_pattern(4'b0101, 2, t0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        wait_valids(2, 8177 + 2048 + 200, "alt");
        stop_run();
        start_pattern(4'b0111, 4, t0);
        exp_q.push_back(16384);
        exp_q.push_back(16384);
        wait_valids(2, 8177 + 2048 + 200, "p75");
        stop_run();

        // Disable 1000 cycles into frame 5, then re-enable with zeros
        start_pattern(4'hF, 1, t0);
        exp_q.push_back(32767);
        exp_q.push_back(32767);
        wait_valids(2, 8177 + 2048 + 200, "pre_dis");
        while (cyc < t0 + 10240 + 1000) tick();
        enable_i = 1'b0;
        idx = vcyc.size();
        repeat (3000) tick();
        chk("dis_no_valid", vcyc.size(), idx);
        chk("dis_pcm_hold", pcm_o, 32767);
        start_pattern(4'h0, 1, t0);
        exp_q.push_back(-32768);
        idx = vcyc.size();
        wait_valids(1, 8177 + 200, "reen");
        if (vcyc.size() > idx) chk("reen_first_lat", vcyc[idx] - t0, 8177);

        // Asynchronous reset mid-frame
        repeat (500) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pcm", pcm_o, 0);
        chk("arst_valid", pcm_valid_o, 0);
        chk("arst_pdm_clk", pdm_clk_o, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        t0 = cyc;
        base = falls;
        exp_q.push_back(-32768);
        idx = vcyc.size();
        wait_valids(1, 8177 + 200, "post_rst");
        if (vcyc.size() > idx) chk("post_rst_first_lat", vcyc[idx] - t0, 8177);
        stop_run();

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
